// File: rtl/sata_link_arbiter_pkg.sv
// Shared SATA link-layer definitions: primitive dwords and arbiter state encodings.
package sata_defines;

  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrStart = 3'd1;
  localparam logic [2:0] StWrBusy  = 3'd2;
  localparam logic [2:0] StRdStart = 3'd3;
  localparam logic [2:0] StRdBusy  = 3'd4;
  localparam logic [2:0] StEscape  = 3'd5;

  function automatic logic is_grant(logic [2:0] st);
    return (st == StWrStart) || (st == StWrBusy) || (st == StRdStart) || (st == StRdBusy);
  endfunction

endpackage

// File: rtl/sata_link_arbiter_if.sv
// Arbiter-facing bundle: PHY status, sub-layer handshakes and the muxed transmit path.
interface sata_link_arbiter_if;
  logic        phy_ready;
  logic        en;
  logic        is_device;
  logic        write_req;
  logic        detect_x_rdy;
  logic        detect_sync;
  logic        wr_idle;
  logic        rd_idle;
  logic [31:0] wr_tx_dout;
  logic [31:0] rd_tx_dout;
  logic        wr_tx_is_k;
  logic        rd_tx_is_k;
  logic [31:0] tx_dout;
  logic        tx_is_k;
  logic        wr_en;
  logic        rd_en;
  logic        wr_phy_ready;
  logic        rd_phy_ready;
  logic        sync_escape;
  logic        timeout;
  logic [2:0]  arb_state;

  modport master (
    output phy_ready, en, is_device, write_req, detect_x_rdy, detect_sync, wr_idle, rd_idle,
           wr_tx_dout, rd_tx_dout, wr_tx_is_k, rd_tx_is_k,
    input  tx_dout, tx_is_k, wr_en, rd_en, wr_phy_ready, rd_phy_ready, sync_escape, timeout,
           arb_state
  );

  modport slave (
    input  phy_ready, en, is_device, write_req, detect_x_rdy, detect_sync, wr_idle, rd_idle,
           wr_tx_dout, rd_tx_dout, wr_tx_is_k, rd_tx_is_k,
    output tx_dout, tx_is_k, wr_en, rd_en, wr_phy_ready, rd_phy_ready, sync_escape, timeout,
           arb_state
  );
endinterface

// File: rtl/sata_align_inserter.sv
// Counts phy_ready cycles and flags two ALIGN slots after every ALIGN_INTERVAL dwords.
module sata_align_inserter #(
  parameter int unsigned ALIGN_INTERVAL = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic phy_ready_i,
  output logic align_slot_o
);

  localparam int unsigned CntW = (ALIGN_INTERVAL > 1) ? $clog2(ALIGN_INTERVAL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ALIGN_INTERVAL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      slots_q, slots_d;

  // slots_q holds the number of ALIGN slots still owed; a slot is consumed only when phy_ready.
  always_comb begin
    cnt_d   = cnt_q;
    slots_d = slots_q;
    if (phy_ready_i) begin
      if (slots_q != 2'd0) begin
        slots_d = slots_q - 2'd1;
      end else if (cnt_q == CntLast) begin
        cnt_d   = '0;
        slots_d = 2'd2;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      slots_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
    end
  end

  assign align_slot_o = (slots_q != 2'd0);

endmodule

// File: rtl/sata_link_arbiter.sv
// SATA link arbiter: grants the PHY to the write or read link FSM, inserts ALIGNs, watchdogs grants.
module sata_link_arbiter
  import sata_defines::*;
#(
  parameter int unsigned ALIGN_INTERVAL = 256,
  parameter int unsigned TIMEOUT        = 1000
) (
  input logic                clk,
  input logic                rst,
  sata_link_arbiter_if.slave bus
);

  localparam logic [15:0] WdLast = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic        align_slot;
  logic        grant;
  logic        expired;

  sata_align_inserter #(
    .ALIGN_INTERVAL(ALIGN_INTERVAL)
  ) u_align (
    .clk_i       (clk),
    .rst_ni      (rst),
    .phy_ready_i (bus.phy_ready),
    .align_slot_o(align_slot)
  );

  assign grant   = is_grant(state_q);
  assign expired = grant && (wd_q == WdLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!align_slot && bus.en && bus.phy_ready) begin
          if (bus.is_device) begin
            if (bus.detect_x_rdy)   state_d = StRdStart;
            else if (bus.write_req) state_d = StWrStart;
          end else begin
            if (bus.write_req)         state_d = StWrStart;
            else if (bus.detect_x_rdy) state_d = StRdStart;
          end
        end
      end
      StWrStart: if (!align_slot && !bus.wr_idle) state_d = StWrBusy;
      StWrBusy:  if (!align_slot && bus.wr_idle)  state_d = StIdle;
      StRdStart: if (!align_slot && !bus.rd_idle) state_d = StRdBusy;
      StRdBusy:  if (!align_slot && bus.rd_idle)  state_d = StIdle;
      StEscape: begin
        if (!align_slot && bus.wr_idle && bus.rd_idle && bus.detect_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Escapes override the ALIGN hold so an expiring watchdog can never be skipped over.
    if (grant && (!bus.en || expired)) state_d = StEscape;
  end

  assign wd_d = ((state_d != state_q) || !grant) ? 16'd0 : wd_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wd_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    bus.tx_dout = PRIM_SYNC;
    bus.tx_is_k = 1'b1;
    if (align_slot) begin
      bus.tx_dout = PRIM_ALIGN;
    end else begin
      case (state_q)
        StWrStart, StWrBusy: begin
          bus.tx_dout = bus.wr_tx_dout;
          bus.tx_is_k = bus.wr_tx_is_k;
        end
        StRdStart, StRdBusy: begin
          bus.tx_dout = bus.rd_tx_dout;
          bus.tx_is_k = bus.rd_tx_is_k;
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_en        = (state_q == StWrStart) || (state_q == StWrBusy);
  assign bus.rd_en        = (state_q == StRdStart) || (state_q == StRdBusy);
  assign bus.wr_phy_ready = bus.phy_ready && !align_slot;
  assign bus.rd_phy_ready = bus.phy_ready && !align_slot;
  assign bus.sync_escape  = (state_q == StEscape);
  assign bus.timeout      = expired;
  assign bus.arb_state    = state_q;

endmodule
